// File: rtl/fmap_rmw_client_pkg.sv
// Shared types for the feature-map read-modify-write requester.
package fmap_rmw_client_pkg;

  typedef enum logic [1:0] {
    OLD_FROM_BRAM = 2'd0,
    OLD_FROM_W    = 2'd1,
    OLD_FROM_P    = 2'd2
  } old_src_e;

endpackage

// File: rtl/fmap_sat_adder.sv
// Combinational per-channel saturating add of a delta vector onto a stored vector.
module fmap_sat_adder #(
  parameter int OUT_CHANNELS    = 2,
  parameter int BITS_PER_NEURON = 8
) (
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] old_i,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] delta_i,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] sum_o
);

  localparam int B = BITS_PER_NEURON;

  // One guard bit is enough: disagreement between the top two bits means overflow.
  function automatic logic [B-1:0] sat_add(input logic signed [B-1:0] a,
                                           input logic signed [B-1:0] b);
    logic signed [B:0] s;
    s = {a[B-1], a} + {b[B-1], b};
    if (s[B] == s[B-1]) return s[B-1:0];
    return s[B] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
  endfunction

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < OUT_CHANNELS; i++) begin
      sum_o[i*B +: B] = sat_add(old_i[i*B +: B], delta_i[i*B +: B]);
    end
  end

endmodule

// File: rtl/fmap_rmw_client.sv
// Pipelined read-modify-write requester: adds event deltas into the feature-map BRAM,
// one event per cycle, with W/P forwarding for close same-coordinate hazards.
module fmap_rmw_client
  import fmap_rmw_client_pkg::*;
#(
  parameter int BITS_PER_COORDINATE = 3,
  parameter int OUT_CHANNELS        = 2,
  parameter int BITS_PER_NEURON     = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable,
  input  logic                                     ev_valid,
  output logic                                     ev_ready,
  input  logic [2*BITS_PER_COORDINATE-1:0]         ev_coord,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]  ev_delta,
  output logic                                     read_req,
  output logic [2*BITS_PER_COORDINATE-1:0]         coord_get,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]  data_out,
  output logic                                     write_req,
  output logic [2*BITS_PER_COORDINATE-1:0]         coord_wtr,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]  data_in,
  output logic                                     busy
);

  localparam int CW = 2*BITS_PER_COORDINATE;
  localparam int FW = OUT_CHANNELS*BITS_PER_NEURON;

  logic          r_valid_q, r_valid_d, d_valid_q, d_valid_d;
  logic          w_valid_q, w_valid_d, p_valid_q, p_valid_d;
  logic [CW-1:0] r_coord_q, r_coord_d, d_coord_q, d_coord_d;
  logic [CW-1:0] w_coord_q, w_coord_d, p_coord_q, p_coord_d;
  logic [FW-1:0] r_delta_q, r_delta_d, d_delta_q, d_delta_d;
  logic [FW-1:0] w_data_q, w_data_d, p_data_q, p_data_d;

  logic          accept;
  old_src_e      old_src;
  logic [FW-1:0] old_val;
  logic [FW-1:0] sum;

  assign accept = ev_valid & enable;

  // P holds the write issued last cycle; the BRAM returns pre-write data for it.
  always_comb begin
    old_src = OLD_FROM_BRAM;
    if (w_valid_q && (w_coord_q == d_coord_q))      old_src = OLD_FROM_W;
    else if (p_valid_q && (p_coord_q == d_coord_q)) old_src = OLD_FROM_P;
  end

  always_comb begin
    case (old_src)
      OLD_FROM_W: old_val = w_data_q;
      OLD_FROM_P: old_val = p_data_q;
      default:    old_val = data_out;
    endcase
  end

  fmap_sat_adder #(
    .OUT_CHANNELS   (OUT_CHANNELS),
    .BITS_PER_NEURON(BITS_PER_NEURON)
  ) u_sat_adder (
    .old_i  (old_val),
    .delta_i(d_delta_q),
    .sum_o  (sum)
  );

  always_comb begin
    r_valid_d = accept;
    r_coord_d = accept ? ev_coord : r_coord_q;
    r_delta_d = accept ? ev_delta : r_delta_q;
    d_valid_d = r_valid_q;
    d_coord_d = r_coord_q;
    d_delta_d = r_delta_q;
    w_valid_d = d_valid_q;
    w_coord_d = d_coord_q;
    w_data_d  = sum;
    p_valid_d = w_valid_q;
    p_coord_d = w_coord_q;
    p_data_d  = w_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_coord_q <= '0;
      r_delta_q <= '0;
      d_valid_q <= 1'b0;
      d_coord_q <= '0;
      d_delta_q <= '0;
      w_valid_q <= 1'b0;
      w_coord_q <= '0;
      w_data_q  <= '0;
      p_valid_q <= 1'b0;
      p_coord_q <= '0;
      p_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_coord_q <= r_coord_d;
      r_delta_q <= r_delta_d;
      d_valid_q <= d_valid_d;
      d_coord_q <= d_coord_d;
      d_delta_q <= d_delta_d;
      w_valid_q <= w_valid_d;
      w_coord_q <= w_coord_d;
      w_data_q  <= w_data_d;
      p_valid_q <= p_valid_d;
      p_coord_q <= p_coord_d;
      p_data_q  <= p_data_d;
    end
  end

  assign ev_ready  = enable;
  assign read_req  = r_valid_q;
  assign coord_get = r_coord_q;
  assign write_req = w_valid_q;
  assign coord_wtr = w_coord_q;
  assign data_in   = w_data_q;
  assign busy      = r_valid_q | d_valid_q | w_valid_q;

endmodule

// File: tb/tb_fmap_rmw_client.sv
// Bench for fmap_rmw_client: BRAM model on both ports, reference accumulator per coordinate.
module tb_fmap_rmw_client;

  logic        clk = 1'b0;
  logic        rst_n, enable, ev_valid;
  logic        ev_ready, read_req, write_req, busy;
  logic [5:0]  ev_coord, coord_get, coord_wtr;
  logic [15:0] ev_delta, data_in;
  logic [15:0] data_out = '0;

  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];

  typedef struct packed {
    logic [5:0]  c;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mdl_e;

  int n_cmp, n_bad, n_writes, n0;
  logic [5:0] base;

  fmap_rmw_client #(
    .BITS_PER_COORDINATE(3),
    .OUT_CHANNELS       (2),
    .BITS_PER_NEURON    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_coord (ev_coord),
    .ev_delta (ev_delta),
    .read_req (read_req),
    .coord_get(coord_get),
    .data_out (data_out),
    .write_req(write_req),
    .coord_wtr(coord_wtr),
    .data_in  (data_in),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // BRAM: port A read with one cycle latency (old data on collision), port B write.
  always @(posedge clk) begin
    if (write_req) mem[coord_wtr] <= data_in;
    if (read_req)  data_out <= mem[coord_get];
  end

  function automatic logic [15:0] ref_add(input logic [15:0] old, input logic [15:0] dl);
    int s;
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      s = int'($signed(old[i*8 +: 8])) + int'($signed(dl[i*8 +: 8]));
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted event updates the coordinate's vector and queues the expected write.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && ev_valid && enable) begin
      ref_mem[ev_coord] = ref_add(ref_mem[ev_coord], ev_delta);
      mdl_e.c = ev_coord;
      mdl_e.d = ref_mem[ev_coord];
      exp_q.push_back(mdl_e);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_req === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("write_without_event", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_coord", 64'(coord_wtr), 64'(mon_e.c));
        check("wr_data", 64'(data_in), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] c, input logic [15:0] d);
    ev_valid = v;
    ev_coord = c;
    ev_delta = d;
  endtask

  task automatic set_mem(input logic [5:0] c, input logic [15:0] v);
    mem[c]     <= v;
    ref_mem[c]  = v;
  endtask

  task automatic drain();
    ev_valid = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_writes = 0;
    rst_n = 1'b0; enable = 1'b0;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 64; i++) set_mem(6'(i), 16'($urandom));
    repeat (2) tick();

    check("rst_read_req",  64'(read_req),  64'd0);
    check("rst_write_req", 64'(write_req), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_coord_get", 64'(coord_get), 64'd0);
    check("rst_coord_wtr", 64'(coord_wtr), 64'd0);
    check("rst_data_in",   64'(data_in),   64'd0);
    check("rst_ev_ready_lo", 64'(ev_ready), 64'd0);
    enable = 1'b1;
    #1;
    check("rst_ev_ready_hi", 64'(ev_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single event: (10,-5) + (3,4) at (2,1)
    set_mem(6'o21, 16'hFB0A);
    tick();
    drive(1'b1, 6'o21, 16'h0403);
    tick();
    drive(1'b0, '0, '0);
    check("t1_read_req", 64'(read_req), 64'd1);
    check("t1_coord_get", 64'(coord_get), 64'o21);
    check("t1_no_early_write", 64'(write_req), 64'd0);
    tick();
    check("t1_read_req_once", 64'(read_req), 64'd0);
    check("t1_write_not_yet", 64'(write_req), 64'd0);
    tick();
    check("t1_write_req", 64'(write_req), 64'd1);
    check("t1_coord_wtr", 64'(coord_wtr), 64'o21);
    check("t1_data_in", 64'(data_in), 64'hFF0D);
    drain();

    // Saturation: (120,-120) + (20,-20)
    set_mem(6'o44, 16'h8878);
    tick();
    drive(1'b1, 6'o44, 16'hEC14);
    tick();
    drive(1'b0, '0, '0);
    repeat (2) tick();
    check("sat_data_in", 64'(data_in), 64'h807F);
    drain();

    // Back-to-back same coordinate: forward from W
    set_mem(6'o11, 16'h0000);
    tick();
    drive(1'b1, 6'o11, 16'h0101);
    tick();
    drive(1'b1, 6'o11, 16'h0202);
    tick();
    drive(1'b0, '0, '0);
    tick();
    check("b2b_first", 64'(data_in), 64'h0101);
    tick();
    check("b2b_second", 64'(data_in), 64'h0303);
    drain();

    // One-cycle gap on same coordinate: forward from P
    set_mem(6'o33, 16'h0505);
    tick();
    drive(1'b1, 6'o33, 16'h0001);
    tick();
    drive(1'b0, '0, '0);
    tick();
    drive(1'b1, 6'o33, 16'h0100);
    tick();
    drive(1'b0, '0, '0);
    repeat (2) tick();
    check("gap_write_req", 64'(write_req), 64'd1);
    check("gap_second", 64'(data_in), 64'h0606);
    drain();

    // Streaming 16 events to distinct coordinates, enable dropped after 10
    n0 = n_writes;
    base = 6'($urandom_range(0, 63));
    for (int i = 0; i < 16; i++) begin
      enable = (i < 10);
      drive(1'b1, base + 6'(i), 16'($urandom));
      if (i == 10) check("stream_ev_ready_lo", 64'(ev_ready), 64'd0);
      tick();
      if (i == 11) check("stream_busy_draining", 64'(busy), 64'd1);
      if (i == 12) check("stream_busy_idle", 64'(busy), 64'd0);
    end
    drain();
    check("stream_write_count", 64'(n_writes - n0), 64'd10);
    enable = 1'b1;

    // Reset with three events in flight
    base = 6'($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, base + 6'(i), 16'($urandom));
      tick();
    end
    drive(1'b0, '0, '0);
    n0 = n_writes;
    rst_n = 1'b0;
    #1;
    check("mid_rst_read_req",  64'(read_req),  64'd0);
    check("mid_rst_write_req", 64'(write_req), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_coord_get", 64'(coord_get), 64'd0);
    check("mid_rst_coord_wtr", 64'(coord_wtr), 64'd0);
    check("mid_rst_data_in",   64'(data_in),   64'd0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_no_write", 64'(n_writes - n0), 64'd0);
    drive(1'b1, base, 16'($urandom));
    tick();
    drain();
    check("post_rst_new_write", 64'(n_writes - n0), 64'd1);

    // Random traffic on a small coordinate set to stress forwarding and saturation
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      drive(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 3)), 16'($urandom));
      tick();
    end
    enable = 1'b1;
    drain();
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 64; i++) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
